rca_config_sequencer: RTL and testbench

Sequences the loading of one reconfigurable custom accelerator (RCA) configuration from a word-addressed configuration memory into the RCA configuration register file. On a start request it walks a config program of 32-bit records from a base address, decodes each record and issues exactly one single-cycle write to the matching configuration register class. It stops on an END record, on an illegal record, on an abort, or when a word limit is reached. It sits between the RCA unit's issue logic and the per-RCA config register file, replacing the one-write-per-instruction configuration path.

---
 rtl/rca_config_sequencer.sv | 154 +++++++++++++++
 tb/tb_rca_config_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rca_config_sequencer.sv
// Walks a config program of 32-bit records in config memory and issues one register-class
// write per record, stopping on END, an illegal record, the word limit or an abort.
module rca_config_sequencer #(
    parameter int unsigned NUM_RCAS   = 4,
    parameter int unsigned CFG_ADDR_W = 8,
    parameter int unsigned MAX_WORDS  = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [$clog2(NUM_RCAS)-1:0]        start_rca_sel,
    input  logic [CFG_ADDR_W-1:0]              start_base,
    input  logic                               abort,
    output logic                               ready,
    output logic                               mem_rd_en,
    output logic [CFG_ADDR_W-1:0]              mem_addr,
    input  logic [31:0]                        mem_rdata,
    output logic [$clog2(NUM_RCAS)-1:0]        cfg_rca_sel,
    output logic                               grid_mux_wr_en,
    output logic                               io_mux_wr_en,
    output logic                               result_mux_wr_en,
    output logic                               io_use_wr_en,
    output logic                               cpu_fb_reg_wr_en,
    output logic                               cpu_nfb_reg_wr_en,
    output logic [11:0]                        cfg_addr,
    output logic [15:0]                        cfg_data,
    output logic                               done,
    output logic                               error,
    output logic                               aborted,
    output logic [$clog2(MAX_WORDS+1)-1:0]     words_loaded
);
    localparam int unsigned SelW = $clog2(NUM_RCAS);
    localparam int unsigned CntW = $clog2(MAX_WORDS + 1);

    typedef enum logic [1:0] {StIdle, StRead, StDecode, StFinish} state_e;

    state_e                state_q, state_d;
    logic [CFG_ADDR_W-1:0] ptr_q, ptr_d;
    logic [SelW-1:0]       sel_q, sel_d;
    logic [CntW-1:0]       words_q, words_d;
    logic [CntW-1:0]       rd_cnt_q, rd_cnt_d;
    logic                  err_q, err_d;
    logic [5:0]            wr_vec;
    logic [3:0]            rec_type;

    assign rec_type          = mem_rdata[31:28];
    assign mem_addr          = ptr_q;
    assign cfg_rca_sel       = sel_q;
    assign words_loaded      = words_q;
    assign grid_mux_wr_en    = wr_vec[0];
    assign io_mux_wr_en      = wr_vec[1];
    assign result_mux_wr_en  = wr_vec[2];
    assign io_use_wr_en      = wr_vec[3];
    assign cpu_fb_reg_wr_en  = wr_vec[4];
    assign cpu_nfb_reg_wr_en = wr_vec[5];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        words_d   = words_q;
        rd_cnt_d  = rd_cnt_q;
        err_d     = err_q;
        ready     = 1'b0;
        mem_rd_en = 1'b0;
        wr_vec    = 6'b0;
        cfg_addr  = 12'h000;
        cfg_data  = 16'h0000;
        done      = 1'b0;
        error     = 1'b0;
        aborted   = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (start) begin
                    sel_d    = start_rca_sel;
                    ptr_d    = start_base;
                    words_d  = '0;
                    rd_cnt_d = '0;
                    err_d    = 1'b0;
                    state_d  = StRead;
                end
            end
            StRead: begin
                if (abort) begin
                    aborted = 1'b1;
                    state_d = StIdle;
                end else begin
                    mem_rd_en = 1'b1;
                    rd_cnt_d  = rd_cnt_q + CntW'(1);
                    state_d   = StDecode;
                end
            end
            StDecode: begin
                // Abort takes priority over the record being decoded this cycle.
                if (abort) begin
                    aborted = 1'b1;
                    state_d = StIdle;
                end else begin
                    case (rec_type)
                        4'd0: begin
                            err_d   = 1'b0;
                            state_d = StFinish;
                        end
                        4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
                            wr_vec   = 6'b000001 << (rec_type - 4'd1);
                            cfg_addr = mem_rdata[27:16];
                            cfg_data = mem_rdata[15:0];
                            words_d  = words_q + CntW'(1);
                            ptr_d    = ptr_q + CFG_ADDR_W'(1);
                            if (rd_cnt_q == CntW'(MAX_WORDS)) begin
                                err_d   = 1'b1;
                                state_d = StFinish;
                            end else begin
                                state_d = StRead;
                            end
                        end
                        default: begin
                            err_d   = 1'b1;
                            state_d = StFinish;
                        end
                    endcase
                end
            end
            StFinish: begin
                if (abort) begin
                    aborted = 1'b1;
                end else begin
                    done  = 1'b1;
                    error = err_q;
                end
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            sel_q    <= '0;
            words_q  <= '0;
            rd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            words_q  <= words_d;
            rd_cnt_q <= rd_cnt_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_rca_config_sequencer.sv
// Bench for rca_config_sequencer: a trace model predicts every output per cycle of each load,
// plus literal checks on completion timing, write counts and read addresses.
module tb_rca_config_sequencer;
    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [1:0]  start_rca_sel;
    logic [7:0]  start_base;
    logic        ready, mem_rd_en;
    logic [7:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic [1:0]  cfg_rca_sel;
    logic        grid_mux_wr_en, io_mux_wr_en, result_mux_wr_en;
    logic        io_use_wr_en, cpu_fb_reg_wr_en, cpu_nfb_reg_wr_en;
    logic [11:0] cfg_addr;
    logic [15:0] cfg_data;
    logic        done, error, aborted;
    logic [2:0]  words_loaded;

    logic [31:0] mem [256];

    always #5 clk = ~clk;

    rca_config_sequencer #(.NUM_RCAS(4), .CFG_ADDR_W(8), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst(rst), .start(start), .start_rca_sel(start_rca_sel),
        .start_base(start_base), .abort(abort), .ready(ready), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .cfg_rca_sel(cfg_rca_sel),
        .grid_mux_wr_en(grid_mux_wr_en), .io_mux_wr_en(io_mux_wr_en),
        .result_mux_wr_en(result_mux_wr_en), .io_use_wr_en(io_use_wr_en),
        .cpu_fb_reg_wr_en(cpu_fb_reg_wr_en), .cpu_nfb_reg_wr_en(cpu_nfb_reg_wr_en),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .done(done), .error(error),
        .aborted(aborted), .words_loaded(words_loaded)
    );

    // Config memory: registered read, data valid the cycle after the strobe.
    always @(posedge clk) mem_rdata <= mem_rd_en ? mem[mem_addr] : 32'hDEAD_BEEF;

    typedef struct packed {
        logic [7:0]  off;
        logic        rdy;
        logic        rd;
        logic [7:0]  addr;
        logic [5:0]  wr;
        logic [11:0] ca;
        logic [15:0] cd;
        logic        dn;
        logic        er;
        logic        ab;
        logic [2:0]  wl;
        logic [1:0]  sel;
    } obs_t;

    obs_t        expq[$];
    obs_t        ce, ca_obs;
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          done_cyc, wr_cnt, abt_cnt, done_cnt, err_cnt;
    logic [7:0]  rd_log[$];
    logic [2:0]  prev_wl = 3'd0;
    logic [1:0]  prev_sel = 2'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin done_cyc = cyc; done_cnt++; end
        if (done && error) err_cnt++;
        if (aborted) abt_cnt++;
        if (mem_rd_en) rd_log.push_back(mem_addr);
        if (grid_mux_wr_en | io_mux_wr_en | result_mux_wr_en | io_use_wr_en |
            cpu_fb_reg_wr_en | cpu_nfb_reg_wr_en) wr_cnt++;
    end

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            ce            = expq.pop_front();
            ca_obs.off    = ce.off;
            ca_obs.rdy    = ready;
            ca_obs.rd     = mem_rd_en;
            ca_obs.addr   = ce.rd ? mem_addr : 8'h00;
            ca_obs.wr     = {cpu_nfb_reg_wr_en, cpu_fb_reg_wr_en, io_use_wr_en,
                             result_mux_wr_en, io_mux_wr_en, grid_mux_wr_en};
            ca_obs.ca     = cfg_addr;
            ca_obs.cd     = cfg_data;
            ca_obs.dn     = done;
            ca_obs.er     = error;
            ca_obs.ab     = aborted;
            ca_obs.wl     = words_loaded;
            ca_obs.sel    = cfg_rca_sel;
            n_tests++;
            if (ca_obs !== ce) begin
                n_fail++;
                $display({"FAIL trace T+%0d: got rdy=%0b rd=%0b addr=%h wr=%b ca=%h cd=%h dn=%0b ",
                          "er=%0b ab=%0b wl=%0d sel=%0d; expected rdy=%0b rd=%0b addr=%h wr=%b ",
                          "ca=%h cd=%h dn=%0b er=%0b ab=%0b wl=%0d sel=%0d"},
                         ce.off, ca_obs.rdy, ca_obs.rd, ca_obs.addr, ca_obs.wr, ca_obs.ca,
                         ca_obs.cd, ca_obs.dn, ca_obs.er, ca_obs.ab, ca_obs.wl, ca_obs.sel,
                         ce.rdy, ce.rd, ce.addr, ce.wr, ce.ca, ce.cd, ce.dn, ce.er, ce.ab,
                         ce.wl, ce.sel);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic obs_t blank(input int off, input logic rdy, input logic [2:0] wl,
                                   input logic [1:0] sel);
        obs_t b;
        b     = '0;
        b.off = 8'(off);
        b.rdy = rdy;
        b.wl  = wl;
        b.sel = sel;
        return b;
    endfunction

    // Predict the per-cycle outputs of one load from the record rules, then drive it.
    // abort_at / start2_at are cycle offsets from the accepting cycle, -1 for none.
    task automatic run_load(input logic [7:0] base, input logic [1:0] sel,
                            input int abort_at, input int start2_at);
        obs_t        e;
        int          k, n, i, guard, off;
        bit          fin_err, abf;
        logic [7:0]  ad;
        logic [31:0] rec;
        logic [3:0]  ty;
        expq.push_back(blank(0, 1'b1, prev_wl, prev_sel));
        k = 1; n = 0; i = 0; fin_err = 0; abf = 0;
        while (1) begin
            ad = base + 8'(i);
            e  = blank(k, 1'b0, 3'(n), sel);
            if (abort_at == k) begin e.ab = 1'b1; expq.push_back(e); abf = 1; break; end
            e.rd = 1'b1; e.addr = ad;
            expq.push_back(e);
            i++; k++;
            rec = mem[ad];
            ty  = rec[31:28];
            e   = blank(k, 1'b0, 3'(n), sel);
            if (abort_at == k) begin e.ab = 1'b1; expq.push_back(e); abf = 1; break; end
            if (ty >= 4'd1 && ty <= 4'd6) begin
                e.wr = 6'b000001 << (ty - 4'd1);
                e.ca = rec[27:16];
                e.cd = rec[15:0];
                expq.push_back(e);
                n++; k++;
                if (i == MAXW) begin fin_err = 1; break; end
            end else begin
                fin_err = (ty != 4'd0);
                expq.push_back(e);
                k++;
                break;
            end
        end
        if (!abf) begin
            e = blank(k, 1'b0, 3'(n), sel);
            if (abort_at == k) e.ab = 1'b1;
            else begin e.dn = 1'b1; e.er = fin_err; end
            expq.push_back(e);
        end
        k++;
        expq.push_back(blank(k, 1'b1, 3'(n), sel));
        prev_wl = 3'(n);
        prev_sel = sel;

        wr_cnt = 0; abt_cnt = 0; done_cnt = 0; err_cnt = 0; done_cyc = -1;
        rd_log.delete();
        t0 = cyc;
        guard = 0;
        while (expq.size() > 0 && guard < 200) begin
            off           = cyc - t0;
            start         = (off == 0) || (off == start2_at);
            abort         = (off == abort_at);
            start_rca_sel = (off == start2_at) ? ~sel : sel;
            start_base    = (off == start2_at) ? base + 8'h40 : base;
            @(posedge clk); #1;
            guard++;
        end
        start = 1'b0;
        abort = 1'b0;
        if (expq.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: got %0d pending cycles, expected 0", expq.size());
            expq.delete();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; start_rca_sel = 2'd0; start_base = 8'h00;
        for (int a = 0; a < 256; a++) mem[a] = 32'h0000_0000;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset ready", int'(ready), 1);
        chk("reset mem_rd_en", int'(mem_rd_en), 0);
        chk("reset mem_addr", int'(mem_addr), 0);
        chk("reset strobes", int'({grid_mux_wr_en, io_mux_wr_en, result_mux_wr_en,
                                   io_use_wr_en, cpu_fb_reg_wr_en, cpu_nfb_reg_wr_en}), 0);
        chk("reset done/error/aborted", int'({done, error, aborted}), 0);
        chk("reset cfg_rca_sel", int'(cfg_rca_sel), 0);
        chk("reset cfg_addr/data", int'({cfg_addr, cfg_data}), 0);
        chk("reset words_loaded", int'(words_loaded), 0);
        @(posedge clk); #1;

        // Two writes then END.
        mem[8'h10] = 32'h1003_0005;
        mem[8'h11] = 32'h2001_0002;
        mem[8'h12] = 32'h0000_0000;
        run_load(8'h10, 2'd2, -1, -1);
        chk("basic done offset", done_cyc - t0, 7);
        chk("basic write count", wr_cnt, 2);
        chk("basic words_loaded", int'(words_loaded), 2);
        chk("basic error count", err_cnt, 0);

        // Illegal first record.
        mem[8'h20] = 32'h9000_0000;
        run_load(8'h20, 2'd1, -1, -1);
        chk("illegal done offset", done_cyc - t0, 3);
        chk("illegal error count", err_cnt, 1);
        chk("illegal words_loaded", int'(words_loaded), 0);

        // Word limit: six writes available, only MAXW read.
        mem[8'h00] = 32'h5001_1111;
        mem[8'h01] = 32'h6002_2222;
        mem[8'h02] = 32'h1003_3333;
        mem[8'h03] = 32'h2004_4444;
        mem[8'h04] = 32'h3005_5555;
        mem[8'h05] = 32'h4006_6666;
        run_load(8'h00, 2'd3, -1, -1);
        chk("limit write count", wr_cnt, 4);
        chk("limit done offset", done_cyc - t0, 9);
        chk("limit error count", err_cnt, 1);
        chk("limit reads", rd_log.size(), 4);
        chk("limit addr 4/5 unread",
            int'(rd_log.size() == 4 && rd_log[3] == 8'h03), 1);

        // Pointer wrap across 0xFF.
        mem[8'hFE] = 32'h300A_1234;
        mem[8'hFF] = 32'h400B_00FF;
        mem[8'h00] = 32'h0000_0000;
        run_load(8'hFE, 2'd0, -1, -1);
        chk("wrap read count", rd_log.size(), 3);
        chk("wrap read order", int'(rd_log.size() == 3 && rd_log[0] == 8'hFE &&
                                    rd_log[1] == 8'hFF && rd_log[2] == 8'h00), 1);
        chk("wrap error count", err_cnt, 0);
        chk("wrap words_loaded", int'(words_loaded), 2);

        // Exactly MAXW reads ending in END is a clean load; a start while busy is dropped.
        mem[8'h60] = 32'h6123_0001;
        mem[8'h61] = 32'h5456_0002;
        mem[8'h62] = 32'h4789_0003;
        mem[8'h63] = 32'h0000_0000;
        run_load(8'h60, 2'd1, -1, 3);
        chk("exact-limit done offset", done_cyc - t0, 9);
        chk("exact-limit error count", err_cnt, 0);

        // Abort in DECODE of the 2nd record, with a coincident start.
        run_load(8'h10, 2'd2, 4, 4);
        chk("abort write count", wr_cnt, 1);
        chk("abort pulses", abt_cnt, 1);
        chk("abort done count", done_cnt, 0);

        // Abort in FINISH suppresses done.
        run_load(8'h10, 2'd3, 7, -1);
        chk("finish-abort done count", done_cnt, 0);
        chk("finish-abort pulses", abt_cnt, 1);

        // Reset in the middle of a load.
        t0 = cyc;
        start = 1'b1; start_rca_sel = 2'd3; start_base = 8'h10;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst ready", int'(ready), 1);
        chk("midrst strobes", int'({mem_rd_en, grid_mux_wr_en, io_mux_wr_en, done, error,
                                    aborted}), 0);
        chk("midrst sel/addr/wl", int'({cfg_rca_sel, mem_addr, words_loaded}), 0);
        prev_wl = 3'd0;
        prev_sel = 2'd0;
        @(posedge clk); #1;
        mem[8'h30] = 32'h6FFF_ABCD;
        mem[8'h31] = 32'h0000_0000;
        run_load(8'h30, 2'd3, -1, 2);
        chk("post-reset done offset", done_cyc - t0, 5);
        chk("post-reset words_loaded", int'(words_loaded), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
